// File: rtl/vex_wb_sequencer.sv
// Writeback sequencer: reserves fixed-latency writeback slots at issue and merges
// FP completions into the free cycles of the single VRF write port.
module vex_wb_sequencer #(
    parameter  int unsigned VECTOR_REGISTERS = 32,
    parameter  int unsigned VECTOR_LANES     = 8,
    parameter  int unsigned XLEN             = 32,
    parameter  int unsigned INT_LAT          = 1,
    parameter  int unsigned MUL_LAT          = 4,
    parameter  int unsigned FP_DEPTH         = 4,
    localparam int unsigned AW               = $clog2(VECTOR_REGISTERS),
    localparam int unsigned DW               = VECTOR_LANES * XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [1:0]              issue_class_i,
    input  logic [AW-1:0]           issue_dst_i,
    input  logic [VECTOR_LANES-1:0] issue_mask_i,
    input  logic                    issue_head_i,
    input  logic                    issue_end_i,
    input  logic [DW-1:0]           int_data_i,
    input  logic [DW-1:0]           mul_data_i,
    input  logic                    fp_done_i,
    input  logic [DW-1:0]           fp_data_i,
    output logic                    fp_ready_o,
    output logic                    wr_valid_o,
    output logic [VECTOR_LANES-1:0] wr_en_o,
    output logic [AW-1:0]           wr_addr_o,
    output logic [DW-1:0]           wr_data_o,
    output logic                    wr_head_o,
    output logic                    wr_end_o,
    output logic                    fp_orphan_o,
    output logic                    idle_o
);

    localparam int unsigned   CW       = $clog2(FP_DEPTH + 1);
    localparam int unsigned   PW       = $clog2(FP_DEPTH);
    localparam logic [CW-1:0] FP_FULL  = CW'(FP_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FP_DEPTH - 1);

    typedef enum logic [1:0] {
        CLS_INT     = 2'd0,
        CLS_MUL     = 2'd1,
        CLS_FP      = 2'd2,
        CLS_INT_ALT = 2'd3
    } uop_class_e;

    typedef struct packed {
        logic [AW-1:0]           dst;
        logic [VECTOR_LANES-1:0] mask;
        logic                    head;
        logic                    last;
        logic                    is_mul;
    } tag_t;

    logic [MUL_LAT-1:0] rsv_q, rsv_d;
    tag_t               slot_q [MUL_LAT];
    tag_t               slot_d [MUL_LAT];
    tag_t               fpq_q  [FP_DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      fp_cnt_q, fp_cnt_d;

    uop_class_e  cls;
    tag_t        new_tag;
    logic        accept, fix_push, fp_push, fp_fire, fp_empty, class_ok;
    int unsigned load_k;

    assign cls      = uop_class_e'(issue_class_i);
    assign new_tag  = '{dst: issue_dst_i, mask: issue_mask_i, head: issue_head_i,
                        last: issue_end_i, is_mul: (cls == CLS_MUL)};
    assign fp_empty = (fp_cnt_q == '0);
    assign fp_fire  = fp_done_i & ~fp_empty & ~rsv_q[0] & ~flush_i;
    assign accept   = issue_valid_i & issue_ready_o;
    assign fp_push  = accept & (cls == CLS_FP);
    assign fix_push = accept & (cls != CLS_FP);
    assign load_k   = (cls == CLS_MUL) ? MUL_LAT - 1 : INT_LAT - 1;

    // Readiness uses the pre-pop FP count, so a same-cycle pop never frees a slot.
    always_comb begin
        case (cls)
            CLS_FP:  class_ok = (fp_cnt_q < FP_FULL);
            CLS_MUL: class_ok = 1'b1;
            default: class_ok = ~rsv_q[INT_LAT];
        endcase
        issue_ready_o = class_ok & ~flush_i & rst_n;
    end

    always_comb begin
        rsv_d = '0;
        for (int unsigned k = 0; k + 1 < MUL_LAT; k++) begin
            rsv_d[k]  = rsv_q[k+1];
            slot_d[k] = slot_q[k+1];
        end
        slot_d[MUL_LAT-1] = '0;
        for (int unsigned k = 0; k < MUL_LAT; k++) begin
            if (fix_push && k == load_k) begin
                rsv_d[k]  = 1'b1;
                slot_d[k] = new_tag;
            end
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fp_cnt_d = fp_cnt_q;
        if (fp_fire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        if (fp_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        case ({fp_push, fp_fire})
            2'b10:   fp_cnt_d = fp_cnt_q + CW'(1);
            2'b01:   fp_cnt_d = fp_cnt_q - CW'(1);
            default: fp_cnt_d = fp_cnt_q;
        endcase

        if (flush_i) begin
            rsv_d = '0;
            for (int unsigned k = 0; k < MUL_LAT; k++) slot_d[k] = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fp_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsv_q <= '0;
            for (int unsigned k = 0; k < MUL_LAT; k++) slot_q[k] <= '0;
            for (int unsigned i = 0; i < FP_DEPTH; i++) fpq_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fp_cnt_q <= '0;
        end else begin
            rsv_q    <= rsv_d;
            slot_q   <= slot_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fp_cnt_q <= fp_cnt_d;
            if (fp_push) fpq_q[wr_ptr_q] <= new_tag;
        end
    end

    always_comb begin
        wr_valid_o = 1'b0;
        wr_en_o    = '0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        wr_head_o  = 1'b0;
        wr_end_o   = 1'b0;
        if (rsv_q[0] && !flush_i) begin
            wr_valid_o = 1'b1;
            wr_en_o    = slot_q[0].mask;
            wr_addr_o  = slot_q[0].dst;
            wr_data_o  = slot_q[0].is_mul ? mul_data_i : int_data_i;
            wr_head_o  = slot_q[0].head;
            wr_end_o   = slot_q[0].last;
        end else if (fp_fire) begin
            wr_valid_o = 1'b1;
            wr_en_o    = fpq_q[rd_ptr_q].mask;
            wr_addr_o  = fpq_q[rd_ptr_q].dst;
            wr_data_o  = fp_data_i;
            wr_head_o  = fpq_q[rd_ptr_q].head;
            wr_end_o   = fpq_q[rd_ptr_q].last;
        end
    end

    assign fp_ready_o  = fp_fire;
    assign fp_orphan_o = rst_n & fp_done_i & fp_empty;
    assign idle_o      = rst_n & ~|rsv_q & fp_empty & ~issue_valid_i;

endmodule

// File: tb/tb_vex_wb_sequencer.sv
// Bench for vex_wb_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a cycle-keyed schedule model.
module tb_vex_wb_sequencer;

    localparam int unsigned NREG = 32, LANES = 8, XL = 32;
    localparam int unsigned INT_LAT = 1, MUL_LAT = 4, FP_DEPTH = 4;
    localparam int unsigned AW = 5, DW = LANES * XL;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i, issue_valid_i, issue_ready_o;
    logic [1:0]       issue_class_i;
    logic [AW-1:0]    issue_dst_i;
    logic [LANES-1:0] issue_mask_i;
    logic             issue_head_i, issue_end_i;
    logic [DW-1:0]    int_data_i, mul_data_i, fp_data_i;
    logic             fp_done_i, fp_ready_o;
    logic             wr_valid_o;
    logic [LANES-1:0] wr_en_o;
    logic [AW-1:0]    wr_addr_o;
    logic [DW-1:0]    wr_data_o;
    logic             wr_head_o, wr_end_o, fp_orphan_o, idle_o;

    vex_wb_sequencer #(
        .VECTOR_REGISTERS(NREG), .VECTOR_LANES(LANES), .XLEN(XL),
        .INT_LAT(INT_LAT), .MUL_LAT(MUL_LAT), .FP_DEPTH(FP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_class_i(issue_class_i), .issue_dst_i(issue_dst_i),
        .issue_mask_i(issue_mask_i), .issue_head_i(issue_head_i), .issue_end_i(issue_end_i),
        .int_data_i(int_data_i), .mul_data_i(mul_data_i),
        .fp_done_i(fp_done_i), .fp_data_i(fp_data_i), .fp_ready_o(fp_ready_o),
        .wr_valid_o(wr_valid_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .wr_head_o(wr_head_o), .wr_end_o(wr_end_o),
        .fp_orphan_o(fp_orphan_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    dst;
        logic [LANES-1:0] mask;
        logic             head;
        logic             last;
        logic             is_mul;
    } tag_t;

    // Model: fixed-latency writebacks keyed by absolute cycle, FP tags in issue order.
    tag_t   sched [longint];
    tag_t   fpq   [$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     fp_hold = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    tag_t          t;
    logic          e_rdy, e_v, e_h, e_e, e_orph, e_idle, fire, acc;
    logic [AW-1:0] e_addr;
    logic [LANES-1:0] e_en;
    logic [DW-1:0] e_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready",  DW'(issue_ready_o), '0);
            chk("rst_valid",  DW'(wr_valid_o),    '0);
            chk("rst_en",     DW'(wr_en_o),       '0);
            chk("rst_addr",   DW'(wr_addr_o),     '0);
            chk("rst_data",   wr_data_o,          '0);
            chk("rst_flags",  DW'({wr_head_o, wr_end_o, fp_ready_o, fp_orphan_o, idle_o}), '0);
            sched.delete();
            fpq.delete();
            fp_hold = 1'b0;
        end else begin
            case (issue_class_i)
                2'd2:    e_rdy = (fpq.size() < int'(FP_DEPTH));
                2'd1:    e_rdy = 1'b1;
                default: e_rdy = !sched.exists(cyc + longint'(INT_LAT));
            endcase
            if (flush_i) e_rdy = 1'b0;
            acc = issue_valid_i && e_rdy;

            e_v = 1'b0; e_en = '0; e_addr = '0; e_data = '0; e_h = 1'b0; e_e = 1'b0; fire = 1'b0;
            if (!flush_i && sched.exists(cyc)) begin
                t = sched[cyc];
                e_v = 1'b1; e_en = t.mask; e_addr = t.dst; e_h = t.head; e_e = t.last;
                e_data = t.is_mul ? mul_data_i : int_data_i;
            end else if (!flush_i && fp_done_i && fpq.size() != 0) begin
                t = fpq[0];
                fire = 1'b1;
                e_v = 1'b1; e_en = t.mask; e_addr = t.dst; e_h = t.head; e_e = t.last;
                e_data = fp_data_i;
            end
            e_orph = fp_done_i && fpq.size() == 0;
            e_idle = sched.num() == 0 && fpq.size() == 0 && !issue_valid_i;

            chk("issue_ready", DW'(issue_ready_o), DW'(e_rdy));
            chk("wr_valid",    DW'(wr_valid_o),    DW'(e_v));
            chk("wr_en",       DW'(wr_en_o),       DW'(e_en));
            chk("wr_addr",     DW'(wr_addr_o),     DW'(e_addr));
            chk("wr_data",     wr_data_o,          e_data);
            chk("wr_head_end", DW'({wr_head_o, wr_end_o}), DW'({e_h, e_e}));
            chk("fp_ready",    DW'(fp_ready_o),    DW'(fire));
            chk("fp_orphan",   DW'(fp_orphan_o),   DW'(e_orph));
            chk("idle",        DW'(idle_o),        DW'(e_idle));

            fp_hold = fp_done_i && !fire && !flush_i && fpq.size() != 0;
            if (flush_i) begin
                sched.delete();
                fpq.delete();
            end else begin
                sched.delete(cyc);
                if (fire) void'(fpq.pop_front());
                if (acc) begin
                    t.dst = issue_dst_i; t.mask = issue_mask_i; t.head = issue_head_i;
                    t.last = issue_end_i; t.is_mul = (issue_class_i == 2'd1);
                    if (issue_class_i == 2'd2) fpq.push_back(t);
                    else sched[cyc + longint'(issue_class_i == 2'd1 ? MUL_LAT : INT_LAT)] = t;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        issue_valid_i = 1'b0; issue_class_i = '0; issue_dst_i = '0; issue_mask_i = '0;
        issue_head_i = 1'b0; issue_end_i = 1'b0; flush_i = 1'b0; fp_done_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [AW-1:0] d, input logic [LANES-1:0] m,
                         input logic h, input logic e);
        issue_valid_i = 1'b1; issue_class_i = c; issue_dst_i = d; issue_mask_i = m;
        issue_head_i = h; issue_end_i = e; flush_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        quiet();
        int_data_i = '0; mul_data_i = '0; fp_data_i = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        #3 chk("post_reset_ready", DW'(issue_ready_o), DW'(1'b1));

        // Basic INT writeback one cycle after issue
        tick(); issue(2'd0, 5'd5, 8'hFF, 1'b1, 1'b1);
        tick(); quiet(); int_data_i = {8{32'h1111_0005}};
        #3 chk("t1_valid", DW'(wr_valid_o), DW'(1'b1));
        chk("t1_addr", DW'(wr_addr_o), DW'(5'd5));
        chk("t1_en",   DW'(wr_en_o),   DW'(8'hFF));
        chk("t1_data", wr_data_o, {8{32'h1111_0005}});

        // INT blocked by a MUL landing in the same writeback cycle
        tick(); issue(2'd1, 5'd3, 8'hA5, 1'b1, 1'b0);
        tick(); quiet();
        tick();
        tick(); issue(2'd0, 5'd7, 8'h0F, 1'b0, 1'b1);
        #3 chk("t2_int_blocked", DW'(issue_ready_o), DW'(1'b0));
        tick(); mul_data_i = {8{32'h2222_0003}};
        #3 chk("t2_int_ready", DW'(issue_ready_o), DW'(1'b1));
        chk("t2_mul_addr", DW'(wr_addr_o), DW'(5'd3));
        chk("t2_mul_en",   DW'(wr_en_o),   DW'(8'hA5));
        chk("t2_mul_data", wr_data_o, {8{32'h2222_0003}});
        tick(); quiet(); int_data_i = {8{32'h3333_0007}};
        #3 chk("t2_int_addr", DW'(wr_addr_o), DW'(5'd7));
        chk("t2_int_data", wr_data_o, {8{32'h3333_0007}});

        // FP queue fills at FP_DEPTH and drains in issue order
        for (int i = 1; i <= 4; i++) begin
            tick(); issue(2'd2, AW'(i), 8'hFF, 1'b1, 1'b1);
            #3 chk("t3_fp_ready_issue", DW'(issue_ready_o), DW'(1'b1));
        end
        tick(); issue(2'd2, 5'd5, 8'hFF, 1'b1, 1'b1);
        #3 chk("t3_fp_full", DW'(issue_ready_o), DW'(1'b0));
        for (int i = 1; i <= 4; i++) begin
            tick(); quiet(); fp_done_i = 1'b1; fp_data_i = {8{32'hF000_0000 + 32'(i)}};
            #3 chk("t3_fp_pop", DW'(fp_ready_o), DW'(1'b1));
            chk("t3_fp_addr", DW'(wr_addr_o), DW'(i));
            chk("t3_fp_data", wr_data_o, {8{32'hF000_0000 + 32'(i)}});
        end
        tick(); quiet();
        #3 chk("t3_idle", DW'(idle_o), DW'(1'b1));

        // FP completion yields to a MUL writeback and retries with held data
        tick(); issue(2'd1, 5'd9, 8'hFF, 1'b1, 1'b1);
        tick(); issue(2'd2, 5'd10, 8'h3C, 1'b0, 1'b1);
        tick(); quiet();
        tick();
        tick(); fp_done_i = 1'b1; fp_data_i = {8{32'h4444_000A}}; mul_data_i = {8{32'h5555_0009}};
        #3 chk("t4_mul_first", DW'(wr_addr_o), DW'(5'd9));
        chk("t4_fp_blocked", DW'(fp_ready_o), DW'(1'b0));
        chk("t4_mul_data", wr_data_o, {8{32'h5555_0009}});
        tick();
        #3 chk("t4_fp_addr", DW'(wr_addr_o), DW'(5'd10));
        chk("t4_fp_ready", DW'(fp_ready_o), DW'(1'b1));
        chk("t4_fp_en",    DW'(wr_en_o),    DW'(8'h3C));
        chk("t4_fp_data",  wr_data_o, {8{32'h4444_000A}});
        tick(); quiet();

        // Flush with MUL and FP tags in flight, then an orphan completion
        tick(); issue(2'd1, 5'd11, 8'hFF, 1'b1, 1'b0);
        tick(); issue(2'd1, 5'd12, 8'hFF, 1'b0, 1'b1);
        tick(); issue(2'd2, 5'd13, 8'hFF, 1'b1, 1'b0);
        tick(); issue(2'd2, 5'd14, 8'hFF, 1'b0, 1'b1);
        tick(); quiet(); flush_i = 1'b1;
        #3 chk("t5_flush_valid", DW'(wr_valid_o), DW'(1'b0));
        chk("t5_flush_ready", DW'(issue_ready_o), DW'(1'b0));
        for (int i = 0; i < 5; i++) begin
            tick(); quiet();
            #3 chk("t5_no_wb", DW'(wr_valid_o), DW'(1'b0));
            chk("t5_idle", DW'(idle_o), DW'(1'b1));
        end
        tick(); fp_done_i = 1'b1;
        #3 chk("t5_orphan", DW'(fp_orphan_o), DW'(1'b1));
        chk("t5_orphan_noready", DW'(fp_ready_o), DW'(1'b0));
        tick(); quiet();
        #3 chk("t5_orphan_end", DW'(fp_orphan_o), DW'(1'b0));

        // Asynchronous reset during an active writeback
        tick(); issue(2'd0, 5'd20, 8'hFF, 1'b1, 1'b1);
        tick(); quiet(); int_data_i = {8{32'h6666_0014}};
        #1 chk("t6_active", DW'(wr_valid_o), DW'(1'b1));
        rst_n = 1'b0;
        #1 chk("t6_rst_valid", DW'(wr_valid_o), DW'(1'b0));
        chk("t6_rst_addr",  DW'(wr_addr_o), '0);
        chk("t6_rst_data",  wr_data_o, '0);
        tick(); tick();
        rst_n = 1'b1;
        issue(2'd0, 5'd21, 8'h81, 1'b1, 1'b0);
        #1 chk("t6_ready_after", DW'(issue_ready_o), DW'(1'b1));
        tick(); quiet(); int_data_i = {8{32'h7777_0015}};
        #3 chk("t6_addr", DW'(wr_addr_o), DW'(5'd21));
        chk("t6_en", DW'(wr_en_o), DW'(8'h81));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (n == 1500) rst_n = 1'b0;
            if (n == 1503) rst_n = 1'b1;
            int_data_i    = rnd_data();
            mul_data_i    = rnd_data();
            flush_i       = ($urandom_range(0, 39) == 0);
            issue_valid_i = ($urandom_range(0, 3) != 0);
            issue_class_i = 2'($urandom_range(0, 3));
            issue_dst_i   = AW'($urandom);
            issue_mask_i  = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom);
            issue_head_i  = 1'($urandom);
            issue_end_i   = 1'($urandom);
            if (fp_hold) begin
                fp_done_i = 1'b1;
            end else if (fpq.size() != 0) begin
                fp_done_i = 1'($urandom_range(0, 1));
                fp_data_i = rnd_data();
            end else begin
                fp_done_i = ($urandom_range(0, 15) == 0);
                fp_data_i = rnd_data();
            end
        end
        tick(); quiet();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
